datapath: RTL
=============

# datapath

Register-transfer datapath of the 8-bit accumulator CPU, sitting directly downstream of the control unit. It consumes the control unit's MUX select, ALU operation and register load strobes. It holds AR, PC, IR, DR, AC and the Z/C flag register, drives the single 8-bit internal bus and the memory port, and returns the instruction byte and flags to the control unit.

## Interface
Parameters:
- `WIDTH`, 8: data/address width.
- `RETIRE_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: system clock; all registers capture on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mux_sel` in 2: bus source; 00 AC, 01 DR, 10 PC, 11 memory read data.
- `alu_op` in 2: 00 ADD, 01 PASS, 10 AND, 11 COM.
- `ar_load`, `pc_load`, `pc_inc`, `ac_load`, `zc_load`, `ir_load`, `dr_load` in 1 each: register load strobes.
- `mem_we_in` in 1: write request from control.
- `mem_rdata` in WIDTH: memory read data, combinational from `mem_addr`.
- `mem_addr` out WIDTH: equals AR.
- `mem_wdata` out WIDTH: equals the bus.
- `mem_we` out 1: equals `mem_we_in`, forced 0 while `rst`.
- `instruction` out WIDTH: equals IR.
- `flag_z`, `flag_c` out 1: flag register contents.
- `dbg_bus`, `dbg_ac`, `dbg_pc` out WIDTH: bus and register values for debugging.
- `retired` out RETIRE_W: count of IR loads.

## Operation
- Bus is combinational from `mux_sel`.
- ALU operand A is AC and operand B is the bus.
  - ADD: {c,r} = A+B, 9-bit.
  - PASS: r = B.
  - AND: r = A&B.
  - COM: r = ~A.
  - c = 0 for every op except ADD.
- Rising-edge register updates:
  - `ar_load`: AR <= bus.
  - `ir_load`: IR <= bus.
  - `dr_load`: DR <= bus.
  - `ac_load`: AC <= r.
  - `zc_load`: Z <= (r == 0) and C <= c, both from the same ALU result that AC captures in that cycle.
  - `pc_load`: PC <= bus. Otherwise, if `pc_inc`, PC <= PC+1, wrapping from 0xFF to 0x00. `pc_load` has priority over `pc_inc`.
- Multiple loads may assert in the same cycle. Each register samples the pre-edge bus independently. A register loading its own bus value (e.g. `ar_load` with `mux_sel`=AC) is legal and ordinary.
- `retired` increments on each `ir_load` and saturates at all-ones.
- Reset: AR, PC, IR, DR, AC, Z, C and `retired` are all 0. `mem_we` is 0. `instruction` is 0x00, which decodes as LDA. Reset mid-instruction discards all partial state immediately; no memory write can occur while `rst` is high.

## Timing
- The control unit changes strobes on the falling edge. The datapath samples them on the next rising edge, so strobes must be stable for a half period.
- Latency for all register loads: 1 rising edge. Outputs reflect the new value right after that edge.
- The bus, ALU result, `mem_addr`, `mem_wdata` and `mem_we` are combinational. There is no added latency from a strobe to the memory port.
- Memory read is asynchronous: `mem_rdata` is valid in the same cycle that AR changes. A memory write commits at the rising edge while `mem_we`=1, to address AR, with data = bus.
- Flags load only with `zc_load`; otherwise they hold. `ac_load` without `zc_load` leaves Z/C unchanged.

## Structure
- Shared package `cpu_pkg` holds:
  - `mux_sel_t` (ACC/DR/PC/MEM);
  - `alu_op_t` (ADD/PASS/AND/COM);
  - opcode constants LDA=00, ADDA=01, STOA=02, JMP=03, COMA=04.
- The control unit and `datapath` both import `cpu_pkg`.
- One sub-module, `alu`: combinational, inputs `a`, `b` and `op`, outputs `r` and `c`. Zero detection stays in `datapath`.
- The datapath contains no opcode decode.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle after loading AC=0x5A and PC=0x10 → all registers, `retired` and `mem_we` read 0 immediately, with no clock edge required.
- ADD with carry: AC=0xF0, `mem_rdata`=0x20, `mux_sel`=MEM, `alu_op`=ADD, `ac_load`+`zc_load` → AC=0x10, C=1, Z=0. Repeat with 0xF0+0x10 → AC=0x00, Z=1, C=1.
- COM and flags hold: AC=0xFF, COM with `ac_load`+`zc_load` → AC=0x00, Z=1, C=0. Then `ac_load` alone with PASS of 0x01 → AC=0x01 while Z=1 and C=0 remain.
- PC priority and wrap:
  - PC=0xFF, `pc_inc` → PC=0x00.
  - `pc_load` and `pc_inc` together with bus=0x42 → PC=0x42.
- Store path: AR=0x30, AC=0x77, `mux_sel`=ACC, `mem_we_in`=1 → `mem_addr`=0x30, `mem_wdata`=0x77, `mem_we`=1 before the edge. Asserting `rst` during the write forces `mem_we`=0.
- Fetch and count: with PC=0x00 and memory[0]=0x03, run AR<=PC then IR<=MEM → `instruction`=0x03 and `retired`=1. Preloading `retired` to 0xFFFF and issuing one more IR load → `retired` stays 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU.
// Imported by the control unit and the datapath.
package cpu_pkg;

  localparam int CPU_W = 8;

  typedef enum logic [1:0] {
    MUX_ACC = 2'b00,
    MUX_DR  = 2'b01,
    MUX_PC  = 2'b10,
    MUX_MEM = 2'b11
  } mux_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_PASS = 2'b01,
    ALU_AND  = 2'b10,
    ALU_COM  = 2'b11
  } alu_op_t;

  localparam logic [CPU_W-1:0] OP_LDA  = 8'h00;
  localparam logic [CPU_W-1:0] OP_ADDA = 8'h01;
  localparam logic [CPU_W-1:0] OP_STOA = 8'h02;
  localparam logic [CPU_W-1:0] OP_JMP  = 8'h03;
  localparam logic [CPU_W-1:0] OP_COMA = 8'h04;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A is the accumulator, B is the bus.
// Carry is only produced by ADD.
module alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] r,
  output logic             c
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    r = '0;
    c = 1'b0;
    unique case (op)
      ALU_ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
      ALU_PASS: r = b;
      ALU_AND:  r = a & b;
      ALU_COM:  r = ~a;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Register-transfer datapath of the accumulator CPU:
// AR/PC/IR/DR/AC, Z/C flags, internal bus and memory port.
module datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mux_sel,
  input  logic [1:0]          alu_op,
  input  logic                ar_load,
  input  logic                pc_load,
  input  logic                pc_inc,
  input  logic                ac_load,
  input  logic                zc_load,
  input  logic                ir_load,
  input  logic                dr_load,
  input  logic                mem_we_in,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  output logic [WIDTH-1:0]    instruction,
  output logic                flag_z,
  output logic                flag_c,
  output logic [WIDTH-1:0]    dbg_bus,
  output logic [WIDTH-1:0]    dbg_ac,
  output logic [WIDTH-1:0]    dbg_pc,
  output logic [RETIRE_W-1:0] retired
);

  logic [WIDTH-1:0]    ar_q;
  logic [WIDTH-1:0]    pc_q;
  logic [WIDTH-1:0]    ir_q;
  logic [WIDTH-1:0]    dr_q;
  logic [WIDTH-1:0]    ac_q;
  logic                z_q;
  logic                c_q;
  logic [RETIRE_W-1:0] ret_q;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;

  always_comb begin
    bus = '0;
    unique case (mux_sel_t'(mux_sel))
      MUX_ACC: bus = ac_q;
      MUX_DR:  bus = dr_q;
      MUX_PC:  bus = pc_q;
      MUX_MEM: bus = mem_rdata;
    endcase
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a (ac_q),
    .b (bus),
    .op(alu_op_t'(alu_op)),
    .r (alu_r),
    .c (alu_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      dr_q  <= '0;
      ac_q  <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ret_q <= '0;
    end else begin
      if (ar_load) ar_q <= bus;
      if (ir_load) ir_q <= bus;
      if (dr_load) dr_q <= bus;
      if (ac_load) ac_q <= alu_r;
      if (zc_load) begin
        z_q <= (alu_r == '0);
        c_q <= alu_c;
      end
      if (pc_load)     pc_q <= bus;
      else if (pc_inc) pc_q <= pc_q + 1'b1;
      // Retired count sticks at all-ones rather than wrapping.
      if (ir_load && ret_q != '1) ret_q <= ret_q + 1'b1;
    end
  end

  assign mem_addr    = ar_q;
  assign mem_wdata   = bus;
  assign mem_we      = mem_we_in & ~rst;
  assign instruction = ir_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign dbg_bus     = bus;
  assign dbg_ac      = ac_q;
  assign dbg_pc      = pc_q;
  assign retired     = ret_q;

endmodule
